f_frame_acc: RTL and testbench
==============================

// Module: f_frame_acc
// PURPOSE
//  Downstream consumer of the f-value stage: takes the registered f word and its rdy strobe,
//  accumulates FRAME_LEN consecutive f values into one frame record (sum, max, sample count),
//  and hands records onward through a 2-entry output buffer with a valid/ready handshake.
//  Decouples the strobe-only f producer (no backpressure) from a stalling consumer; drops and flags on overflow.
// PARAMETERS
//  DW         `Datawidth                   input datapath width; f word is DW+3 bits
//  FRAME_LEN  8                            samples per frame, >=2
//  CNT_W      $clog2(FRAME_LEN+1)          sample-count width
//  ACC_W      DW+3+$clog2(FRAME_LEN)       sum width, never overflows for a full frame
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst_n      in   1      synchronous reset, active low
//  f_in       in   DW+3   f value, unsigned; sampled only when f_rdy=1
//  f_rdy      in   1      one sample strobe per cycle; may be back-to-back or gapped
//  flush      in   1      close current partial frame
//  out_sum    out  ACC_W  head record: sum of samples
//  out_max    out  DW+3   head record: largest sample
//  out_cnt    out  CNT_W  head record: samples in frame (1..FRAME_LEN)
//  out_valid  out  1      head record valid
//  out_ready  in   1      consumer accepts head when out_valid & out_ready
//  ovf        out  1      sticky: a completed frame was dropped
//  busy       out  1      partial frame open (cnt_r != 0)
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): cnt_r, sum_r, max_r, FIFO pointers/occupancy, ovf -> 0; out_* data -> 0,
//   out_valid=0, busy=0. Reset mid-frame discards the partial frame and all buffered records.
//  States: IDLE (cnt_r=0) / ACC (cnt_r>0); no other states.
//   IDLE --f_rdy--> ACC (sum_r=f_in, max_r=f_in, cnt_r=1).
//   ACC --f_rdy, cnt_r<FRAME_LEN-1--> ACC (sum_r+=f_in, max_r=max(max_r,f_in), cnt_r++).
//   ACC --f_rdy with cnt_r=FRAME_LEN-1, or flush--> IDLE, record pushed.
//  Flush: in ACC, flush & f_rdy same cycle -> sample included, then record closed.
//   In IDLE, flush & f_rdy -> one-sample record (cnt=1). In IDLE, flush alone -> ignored.
//  Latency: record appears at out_valid on the edge after the completing strobe (1 cycle);
//   f_rdy on that same cycle opens the next frame, no bubble.
//  Output buffer: 2-entry FIFO, head shown on out_*; out_* hold stable while out_valid & !out_ready.
//   Pop and push in the same cycle always legal, including when full (pop frees the slot).
//   Push when full with no pop: record dropped, ovf <= 1 (sticky until reset), accumulator still
//   returns to IDLE. Pop when empty: no effect.
//  Arithmetic: all unsigned; f_in zero-extended to ACC_W; max compare unsigned; ties keep old value.
//  No combinational path from f_rdy/flush to out_*; out_valid depends only on FIFO state.
// STRUCTURE
//  `Datawidth comes from define.v (shared); add there `F_FRAME_LEN default if used by other stages.
//  Record packing {sum,max,cnt} as a localparam-width vector; one sub-module: f_rec_fifo
//  (2-entry synchronous FIFO, width ACC_W+DW+3+CNT_W, push/pop/full/empty, sync active-low reset).
// TESTING (DW=16, FRAME_LEN=4, out_ready=1 unless stated)
//  1 strobes f=1,2,3,4 back-to-back -> one cycle later out_valid=1, sum=10, max=4, cnt=4; busy 0 after.
//  2 f=7,(gap 3 cycles),2, then flush alone -> record sum=9, max=7, cnt=2; flush in IDLE -> nothing.
//  3 out_ready=0, 3 full frames of f=0x7FFFF x4 -> first two held (sum=0x1FFFFC), third dropped,
//    ovf=1; raise out_ready -> exactly 2 records drain, ovf stays 1.
//  4 FIFO full, frame completes same cycle as pop -> no drop, ovf=0, records in order.
//  5 rst_n=0 after 2 strobes of frame -> out_valid=0, busy=0, ovf=0; next 4 strobes give cnt=4 clean.
//  6 flush & f_rdy(f=5) in IDLE -> record sum=5, max=5, cnt=1.

Source files
------------

// File: rtl/f_frame_acc_pkg.sv
// Shared types and helpers for the f-value frame accumulator.
package f_frame_acc_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StAcc
  } acc_state_e;

  // Width of one packed {sum, max, cnt} record.
  function automatic int unsigned rec_width(input int unsigned acc_w, input int unsigned dw,
                                            input int unsigned cnt_w);
    return acc_w + dw + 3 + cnt_w;
  endfunction

endpackage

// File: rtl/f_rec_fifo.sv
// Two-entry synchronous FIFO holding packed frame records; head is always visible on rdata.
module f_rec_fifo
  import f_frame_acc_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);
  assign rdata = mem_q[rd_ptr_q];

  // A pop frees the slot, so a simultaneous push into a full FIFO is accepted.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/f_frame_acc.sv
// Accumulates FRAME_LEN f samples into {sum, max, cnt} records and buffers them for a
// stalling consumer; completed frames that find the buffer full are dropped and flagged.
module f_frame_acc
  import f_frame_acc_pkg::*;
#(
  parameter int unsigned DW        = 16,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1),
  parameter int unsigned ACC_W     = DW + 3 + $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW+2:0]    f_in,
  input  logic             f_rdy,
  input  logic             flush,
  output logic [ACC_W-1:0] out_sum,
  output logic [DW+2:0]    out_max,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned RecW = rec_width(ACC_W, DW, CNT_W);

  acc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;
  logic [ACC_W-1:0] sum_q, sum_d, sum_n;
  logic [DW+2:0]    max_q, max_d, max_n;
  logic             push, close;
  logic             ovf_q;
  logic             fifo_full, fifo_empty;
  logic [RecW-1:0]  rec_in, rec_head;

  always_comb begin
    state_d = state_q;
    cnt_n   = cnt_q;
    sum_n   = sum_q;
    max_n   = max_q;
    close   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (f_rdy) begin
          cnt_n = CNT_W'(1);
          sum_n = ACC_W'(f_in);
          max_n = f_in;
        end
        // Flush with nothing open is ignored; with a same-cycle sample it closes a 1-sample frame.
        close = f_rdy & flush;
      end
      StAcc: begin
        if (f_rdy) begin
          cnt_n = cnt_q + CNT_W'(1);
          sum_n = sum_q + ACC_W'(f_in);
          max_n = (f_in > max_q) ? f_in : max_q;
        end
        close = flush | (f_rdy & (cnt_q == CNT_W'(FRAME_LEN - 1)));
      end
      default: ;
    endcase

    push   = close;
    rec_in = {sum_n, max_n, cnt_n};
    if (close) begin
      cnt_d   = '0;
      sum_d   = '0;
      max_d   = '0;
      state_d = StIdle;
    end else begin
      cnt_d   = cnt_n;
      sum_d   = sum_n;
      max_d   = max_n;
      state_d = (cnt_n != '0) ? StAcc : StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      if (push && fifo_full && !out_ready) begin
        ovf_q <= 1'b1;
      end
    end
  end

  f_rec_fifo #(
    .Width(RecW)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(rec_in),
    .pop  (out_ready),
    .rdata(rec_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign {out_sum, out_max, out_cnt} = rec_head;
  assign out_valid = ~fifo_empty;
  assign ovf       = ovf_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_f_frame_acc.sv
// Directed bench for f_frame_acc with a queue-based frame model checked every cycle.
module tb_f_frame_acc;

  localparam int unsigned DW    = 16;
  localparam int unsigned FL    = 4;
  localparam int unsigned CNT_W = $clog2(FL + 1);
  localparam int unsigned ACC_W = DW + 3 + $clog2(FL);

  typedef struct {
    longint sum;
    longint mx;
    longint cnt;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DW+2:0]    f_in;
  logic             f_rdy;
  logic             flush;
  logic [ACC_W-1:0] out_sum;
  logic [DW+2:0]    out_max;
  logic [CNT_W-1:0] out_cnt;
  logic             out_valid;
  logic             out_ready;
  logic             ovf;
  logic             busy;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  rec_t   mq[$];
  rec_t   m_rec, m_dummy;
  longint m_sum, m_max, m_n;
  bit     m_ovf, m_close;

  f_frame_acc #(
    .DW       (DW),
    .FRAME_LEN(FL),
    .CNT_W    (CNT_W),
    .ACC_W    (ACC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .f_in     (f_in),
    .f_rdy    (f_rdy),
    .flush    (flush),
    .out_sum  (out_sum),
    .out_max  (out_max),
    .out_cnt  (out_cnt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ovf      (ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Frame-level model: samples, records, 2-deep buffer, sticky drop flag.
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_sum = 0;
      m_max = 0;
      m_n   = 0;
      m_ovf = 0;
    end else begin
      if (f_rdy) begin
        m_sum += f_in;
        if (f_in > m_max) m_max = f_in;
        m_n++;
      end
      m_close = (m_n == FL) || (flush && m_n > 0);
      if (m_close) begin
        m_rec = '{m_sum, m_max, m_n};
        m_sum = 0;
        m_max = 0;
        m_n   = 0;
      end
      if (out_ready && mq.size() > 0) m_dummy = mq.pop_front();
      if (m_close) begin
        if (mq.size() < 2) mq.push_back(m_rec);
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", out_valid, mq.size() != 0);
      check("busy", busy, m_n != 0);
      check("ovf", ovf, m_ovf);
      if (mq.size() != 0) begin
        check("out_sum", out_sum, mq[0].sum);
        check("out_max", out_max, mq[0].mx);
        check("out_cnt", out_cnt, mq[0].cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [DW+2:0] f, input logic fl);
    f_in  = f;
    f_rdy = 1'b1;
    flush = fl;
    tick();
    f_rdy = 1'b0;
    flush = 1'b0;
  endtask

  task automatic lit_head(input string tag, input longint s, input longint m, input longint c);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sum"}, out_sum, s);
    check({tag, "_max"}, out_max, m);
    check({tag, "_cnt"}, out_cnt, c);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_sum", out_sum, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    f_in      = '0;
    f_rdy     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_en = 1'b1;
    do_reset();

    // 1: full frame back-to-back
    for (int i = 1; i <= 4; i++) strobe(19'(i), 1'b0);
    lit_head("t1", 10, 4, 4);
    check("t1_busy", busy, 0);
    tick();
    check("t1_drained", out_valid, 0);

    // 2: gapped samples closed by flush, then flush in idle
    strobe(19'd7, 1'b0);
    repeat (3) tick();
    strobe(19'd2, 1'b0);
    check("t2_busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    lit_head("t2", 9, 7, 2);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t2_idle_flush", out_valid, 0);
    check("t2_idle_busy", busy, 0);

    // 3: stalled consumer, third frame dropped
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) strobe(19'h7FFFF, 1'b0);
    lit_head("t3", 'h1FFFFC, 'h7FFFF, 4);
    check("t3_ovf", ovf, 1);
    out_ready = 1'b1;
    tick();
    check("t3_second", out_valid, 1);
    tick();
    check("t3_empty", out_valid, 0);
    check("t3_ovf_sticky", ovf, 1);
    do_reset();

    // 4: completion coincides with a pop while full
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(19'd1, 1'b0);
    for (int i = 0; i < 4; i++) strobe(19'd2, 1'b0);
    for (int i = 0; i < 3; i++) strobe(19'd3, 1'b0);
    out_ready = 1'b1;
    strobe(19'd3, 1'b0);
    out_ready = 1'b0;
    check("t4_ovf", ovf, 0);
    lit_head("t4b", 8, 2, 4);
    out_ready = 1'b1;
    tick();
    lit_head("t4c", 12, 3, 4);
    tick();
    check("t4_empty", out_valid, 0);

    // 5: reset mid-frame
    strobe(19'd9, 1'b0);
    strobe(19'd9, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) strobe(19'd1, 1'b0);
    lit_head("t5", 4, 1, 4);
    tick();

    // 6: flush with sample in idle
    strobe(19'd5, 1'b1);
    lit_head("t6", 5, 5, 1);
    check("t6_busy", busy, 0);
    repeat (2) tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
